// File: rtl/pipe_pkg.sv
// Shared types and constants for the handshaked pipeline-stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_BUSY  = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_e;

  localparam int PIPE_CTRL_W = 9;
  localparam int PIPE_DATA_W = 133;

  // Control bundle layout, MSB first: RegDst, AluOp[1:0], AluSrc, Branch,
  // MemRead, MemWrite, RegWrite, MemToReg.
  localparam int CTRL_REGDST   = 8;
  localparam int CTRL_ALUOP_HI = 7;
  localparam int CTRL_ALUOP_LO = 6;
  localparam int CTRL_ALUSRC   = 5;
  localparam int CTRL_BRANCH   = 4;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_REGWRITE = 1;
  localparam int CTRL_MEMTOREG = 0;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with increment enable and asynchronous active-low clear.
module pipe_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline-stage register with flush and saturating stall counter.
// Define PIPE_SKID_EN to add a skid entry and a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        dbg_state
);

  // Handshake: a transfer happens on a rising clk edge where valid and ready
  // are both 1; valid never depends on ready of the same interface.

  pipe_state_e       state_q, state_d;
  logic              load_m;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;

`ifdef PIPE_SKID_EN
  logic              load_s;
  logic              m_from_s;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] s_data;

  // Derived from the state register only, so out_ready never reaches in_ready.
  assign in_ready = (state_q != PS_FULL);
`else
  assign in_ready = out_ready | ~out_valid;
`endif

  assign out_valid = (state_q != PS_EMPTY);
  assign out_ctrl  = m_ctrl & {CTRL_W{out_valid}};
  assign out_data  = m_data;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    load_m  = 1'b0;
`ifdef PIPE_SKID_EN
    load_s   = 1'b0;
    m_from_s = 1'b0;
`endif
    case (state_q)
      PS_EMPTY: begin
        if (in_valid) begin
          state_d = PS_BUSY;
          load_m  = 1'b1;
        end
      end
      PS_BUSY: begin
        if (out_ready) begin
          if (in_valid) load_m = 1'b1;
          else          state_d = PS_EMPTY;
        end
`ifdef PIPE_SKID_EN
        else if (in_valid) begin
          state_d = PS_FULL;
          load_s  = 1'b1;
        end
`endif
      end
`ifdef PIPE_SKID_EN
      PS_FULL: begin
        if (out_ready) begin
          state_d  = PS_BUSY;
          m_from_s = 1'b1;
        end
      end
`endif
      default: state_d = PS_EMPTY;
    endcase

    // Flush wins: the held entries and any entry offered this cycle are dropped.
    if (flush) begin
      state_d = PS_EMPTY;
      load_m  = 1'b0;
`ifdef PIPE_SKID_EN
      load_s   = 1'b0;
      m_from_s = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PS_EMPTY;
      m_ctrl  <= '0;
      m_data  <= '0;
    end else begin
      state_q <= state_d;
      if (load_m) begin
        m_ctrl <= in_ctrl;
        m_data <= in_data;
      end
`ifdef PIPE_SKID_EN
      else if (m_from_s) begin
        m_ctrl <= s_ctrl;
        m_data <= s_data;
      end
`endif
    end
  end

`ifdef PIPE_SKID_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_ctrl <= '0;
      s_data <= '0;
    end else if (load_s) begin
      s_ctrl <= in_ctrl;
      s_data <= in_data;
    end
  end
`endif

  pipe_sat_cnt #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .clr_n (reset_n),
    .inc   (out_valid & ~out_ready),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg against a queue-based occupancy model.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int CTRL_W = PIPE_CTRL_W;
  localparam int DATA_W = PIPE_DATA_W;
  localparam int CNT_W  = 16;
  localparam int E_W    = CTRL_W + DATA_W;
  localparam longint STALL_MAX = (longint'(1) << CNT_W) - 1;
`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DATA_W-1:0] in_data, out_data;
  logic [CNT_W-1:0]  stall_cnt;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .stall_cnt (stall_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [E_W-1:0] exp_q[$];
  longint     exp_stall = 0;
  bit         m_rdy, m_out_x, m_in_x;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // The stage accepts while it has room; without a skid entry it also accepts
  // when its single entry leaves in the same cycle.
  function automatic bit model_in_ready();
`ifdef PIPE_SKID_EN
    return exp_q.size() < CAP;
`else
    return out_ready || (exp_q.size() == 0);
`endif
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
      exp_stall = 0;
    end else begin
      m_rdy   = model_in_ready();
      m_out_x = (exp_q.size() > 0) && out_ready;
      m_in_x  = in_valid && m_rdy;
      if ((exp_q.size() > 0) && !out_ready && (exp_stall < STALL_MAX)) exp_stall++;
      if (m_out_x) void'(exp_q.pop_front());
      if (flush) exp_q.delete();
      else if (m_in_x) exp_q.push_back({in_ctrl, in_data});
    end
  end

  always @(negedge clk) begin
    logic [E_W-1:0] e;
    e = (exp_q.size() > 0) ? exp_q[0] : '0;
    chk("out_valid", out_valid, exp_q.size() > 0);
    chk("out_ctrl", out_ctrl, (exp_q.size() > 0) ? e[E_W-1:DATA_W] : '0);
    if (exp_q.size() > 0) chk("out_data", out_data, e[DATA_W-1:0]);
    chk("in_ready", in_ready, model_in_ready());
    chk("stall_cnt", stall_cnt, exp_stall[CNT_W-1:0]);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit iv, input bit ordy, input bit fl);
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    in_ctrl   = CTRL_W'($urandom);
    in_data   = r[DATA_W-1:0];
  endtask

  logic [CTRL_W-1:0] sent_ctrl[8];
  logic [DATA_W-1:0] sent_data[8];
  logic [DATA_W-1:0] a_data, b_data, c_data, d_data;

  // ---------------- stimulus ----------------
  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 9'h1FF;
    in_data   = '1;
    out_ready = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_ctrl", out_ctrl, 9'h000);
    chk("rst_out_data", out_data, '0);
    chk("rst_stall_cnt", stall_cnt, 16'h0000);
    chk("rst_in_ready", in_ready, 1'b1);
    step();
    step();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("first_load_ctrl", out_ctrl, 9'h1FF);
    chk("first_load_valid", out_valid, 1'b1);

    // Full-rate stream, one-cycle latency
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b1, 1'b0);
      sent_ctrl[k] = in_ctrl;
      sent_data[k] = in_data;
      #1;
      chk("stream_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
      chk("stream_ctrl", out_ctrl, sent_ctrl[k]);
      chk("stream_data", out_data, sent_data[k]);
    end
    drive(1'b0, 1'b1, 1'b0);
    step();
    step();

    // Backpressure: A held, B waits (skid entry or upstream), both emerge in order
    drive(1'b1, 1'b0, 1'b0);
    a_data = in_data;
    step();
    drive(1'b1, 1'b0, 1'b0);
    b_data = in_data;
    step();
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_hold_a", out_data, a_data);
`ifdef PIPE_SKID_EN
    chk("bp_state_full", dbg_state, PS_FULL);
`endif
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    chk("bp_then_b", out_data, b_data);
    chk("bp_b_valid", out_valid, 1'b1);
    step();
    chk("bp_drained", out_valid, 1'b0);

    // Flush while blocked, with C offered in the flush cycle
    drive(1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b0, 1'b1);
    c_data = in_data;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_ctrl", out_ctrl, 9'h000);
    out_ready = 1'b1;
    step();
    step();
    chk("flush_c_absent", out_valid, 1'b0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      step();
    end

    // Stall counter saturation
    drive(1'b1, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 70000; i++) @(posedge clk);
    #1;
    chk("stall_sat", stall_cnt, 16'hFFFF);
    step();
    chk("stall_sat_hold", stall_cnt, 16'hFFFF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("stall_after_flush", stall_cnt, 16'hFFFF);
    chk("stall_flush_empty", out_valid, 1'b0);

    // Asynchronous reset pulse mid-stream
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      step();
    end
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_stall", stall_cnt, 16'h0000);
    drive(1'b1, 1'b1, 1'b0);
    d_data = in_data;
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_valid", out_valid, 1'b1);
    chk("post_rst_data", out_data, d_data);

    drive(1'b0, 1'b1, 1'b0);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
